// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the power-on reset sequencer: FSM state encoding,
// stage-counter width helper and board default delays for a 50 MHz clock.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_INIT_WAIT  = 2'd1,
    ST_STAGE_WAIT = 2'd2,
    ST_DONE       = 2'd3
  } seq_state_e;

  // 50 MHz board clock; 1000 cycles = 20 us between lock and each release.
  localparam int unsigned CLK_HZ        = 32'd50_000_000;
  localparam int unsigned DEF_INIT_DLY  = 32'd1000;
  localparam int unsigned DEF_STAGE_DLY = 32'd1000;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Width of a counter that must represent 0..num_ch released channels.
  function automatic int stage_width(input int num_ch);
    return clog2_f(num_ch + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear to 0.
module sync_ff
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for a synchronised PLL lock, then releases
// NUM_CH active-low reset domains in ascending order. Any lock loss restarts
// the whole sequence. Optional macro SEQ_SOFT_RST_EN adds a synchronous
// soft_rst input that behaves exactly like a lock loss.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int INIT_DLY    = DEF_INIT_DLY,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
`ifdef SEQ_SOFT_RST_EN
  input  logic                             soft_rst,
`endif
  output logic [NUM_CH-1:0]                sys_rst_n,
  output logic                             seq_done,
  output logic [stage_width(NUM_CH)-1:0]   stage
);

  localparam int STG_W = stage_width(NUM_CH);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_DLY - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [STG_W-1:0] LAST_CH    = STG_W'(NUM_CH - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] r_sys_rst_n, w_sys_rst_n_nxt;
  logic              r_done, w_done_nxt;
  logic [STG_W-1:0]  r_stage, w_stage_nxt;
  logic              w_lock_s;
  logic              w_soft;
  logic              w_restart;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

`ifdef SEQ_SOFT_RST_EN
  assign w_soft = soft_rst;
`else
  assign w_soft = 1'b0;
`endif

  // Lock loss and soft restart share one path; it outranks any release.
  assign w_restart = !w_lock_s || w_soft;

  // Next-state, counter and release decisions for the sequencing FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sys_rst_n_nxt = r_sys_rst_n;
    w_done_nxt      = r_done;
    w_stage_nxt     = r_stage;
    if (w_restart) begin
      w_state_nxt     = ST_HOLD;
      w_cnt_nxt       = '0;
      w_sys_rst_n_nxt = '0;
      w_done_nxt      = 1'b0;
      w_stage_nxt     = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_cnt_nxt       = '0;
          w_sys_rst_n_nxt = '0;
          w_done_nxt      = 1'b0;
          w_stage_nxt     = '0;
          w_state_nxt     = ST_INIT_WAIT;
        end
        ST_INIT_WAIT: begin
          if (r_cnt == INIT_LAST) begin
            w_cnt_nxt       = '0;
            w_sys_rst_n_nxt = r_sys_rst_n | NUM_CH'(1'b1);
            w_stage_nxt     = STG_W'(1'b1);
            if (NUM_CH == 1) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_STAGE_WAIT;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
          end
        end
        ST_STAGE_WAIT: begin
          if (r_cnt == STAGE_LAST) begin
            w_cnt_nxt       = '0;
            w_sys_rst_n_nxt = r_sys_rst_n | (NUM_CH'(1'b1) << r_stage);
            w_stage_nxt     = r_stage + STG_W'(1'b1);
            if (r_stage == LAST_CH) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_STAGE_WAIT;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt     = ST_HOLD;
          w_cnt_nxt       = '0;
          w_sys_rst_n_nxt = '0;
          w_done_nxt      = 1'b0;
          w_stage_nxt     = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_sys_rst_n <= '0;
      r_done      <= 1'b0;
      r_stage     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sys_rst_n <= w_sys_rst_n_nxt;
      r_done      <= w_done_nxt;
      r_stage     <= w_stage_nxt;
    end
  end

  assign sys_rst_n = r_sys_rst_n;
  assign seq_done  = r_done;
  assign stage     = r_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a 3-channel instance (INIT 10, STAGE 5) and a
// 1-channel instance (INIT 1) share the same clock, reset and lock stimulus.
// Both are compared every cycle against a timeline model: the release count
// is derived from edges elapsed since the sequence started.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst;
  logic [2:0] a_sys;
  logic       a_done;
  logic [1:0] a_stage;
  logic [0:0] b_sys;
  logic       b_done;
  logic [0:0] b_stage;

  int n_cmp;
  int n_mis;

  // Reference model state.
  bit [1:0] m_sync;
  bit       m_active;
  int       m_e;

  reset_sequencer #(
    .NUM_CH(3), .INIT_DLY(10), .STAGE_DLY(5), .CNT_W(16), .SYNC_STAGES(2)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
`ifdef SEQ_SOFT_RST_EN
    .soft_rst   (soft_rst),
`endif
    .sys_rst_n  (a_sys),
    .seq_done   (a_done),
    .stage      (a_stage)
  );

  reset_sequencer #(
    .NUM_CH(1), .INIT_DLY(1), .STAGE_DLY(1), .CNT_W(16), .SYNC_STAGES(2)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
`ifdef SEQ_SOFT_RST_EN
    .soft_rst   (soft_rst),
`endif
    .sys_rst_n  (b_sys),
    .seq_done   (b_done),
    .stage      (b_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channels released after e edges since the sequence start.
  function automatic int released(int e, int nch, int init_d, int stg_d);
    int r;
    if (e < init_d) begin
      r = 0;
    end else begin
      r = 1 + (e - init_d) / stg_d;
      if (r > nch) r = nch;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    int ra;
    int rb;
    ra = m_active ? released(m_e, 3, 10, 5) : 0;
    rb = m_active ? released(m_e, 1, 1, 1) : 0;
    chk("a_sys_rst_n", 32'(a_sys), (32'd1 << ra) - 32'd1);
    chk("a_seq_done", 32'(a_done), (ra == 3) ? 32'd1 : 32'd0);
    chk("a_stage", 32'(a_stage), 32'(ra));
    chk("b_sys_rst_n", 32'(b_sys), (32'd1 << rb) - 32'd1);
    chk("b_seq_done", 32'(b_done), (rb == 1) ? 32'd1 : 32'd0);
    chk("b_stage", 32'(b_stage), 32'(rb));
  endtask

  // Advance the model by one clock edge using the pre-edge inputs.
  task automatic model_edge();
    bit lk;
    lk = m_sync[1];
    m_sync = {m_sync[0], pll_locked};
    if (m_active) begin
      if (!lk || soft_rst) begin
        m_active = 1'b0;
        m_e = 0;
      end else begin
        m_e++;
      end
    end else begin
      if (lk && !soft_rst) begin
        m_active = 1'b1;
        m_e = 0;
      end else begin
        m_e = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model reaches elapsed count 'target', bounded.
  task automatic wait_e(int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!hit) begin
        if (m_active && m_e == target) hit = 1'b1;
        else step();
      end
    end
    if (!hit && m_active && m_e == target) hit = 1'b1;
    chk("wait_e_reached", 32'(hit), 32'd1);
  endtask

  task automatic async_reset_pulse(int cycles);
    #2;
    rst_n = 1'b0;
    m_active = 1'b0;
    m_e = 0;
    m_sync = 2'b00;
    #1;
    check_all();
    run(cycles);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    m_sync = 2'b00;
    m_active = 1'b0;
    m_e = 0;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    soft_rst = 1'b0;

    // Reset state, before and across a few edges.
    #1;
    check_all();
    run(3);
    rst_n = 1'b1;

    // Lock held low: nothing may be released.
    run(200);

    // Normal sequence, then lock loss at T0+17 and relock.
    pll_locked = 1'b1;
    wait_e(17);
    pll_locked = 1'b0;
    run(8);
    pll_locked = 1'b1;
    wait_e(25);
    run(5);

    // Asynchronous reset mid-sequence at T0+12, then restart.
    pll_locked = 1'b0;
    run(4);
    pll_locked = 1'b1;
    wait_e(12);
    async_reset_pulse(3);
    wait_e(22);

    // Single-cycle lock glitch after completion.
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    run(30);

`ifdef SEQ_SOFT_RST_EN
    // One-cycle soft restart after completion, then a held soft restart.
    wait_e(22);
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    run(30);
    soft_rst = 1'b1;
    run(10);
    soft_rst = 1'b0;
    run(30);
`endif

    // Randomised lock (and soft restart) activity.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (pll_locked) begin
        if (r < 3) pll_locked = 1'b0;
      end else begin
        if (r < 30) pll_locked = 1'b1;
      end
`ifdef SEQ_SOFT_RST_EN
      soft_rst = ($urandom_range(0, 149) == 0);
`endif
      if ($urandom_range(0, 399) == 0) begin
        async_reset_pulse(2);
      end else begin
        step();
      end
    end
    soft_rst = 1'b0;
    pll_locked = 1'b1;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
